// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared constants for the period meter.
// Contents:
//   ST_IDLE / ST_MEASURE  state encoding of the measurement FSM
//   N_DEF / TIMEOUT_DEF   default counter width and timeout (2 s at 50 MHz)
//   CLK_HZ                system clock rate, for converting results to Hz
package period_meter_pkg;
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MEASURE = 1'b1;
    localparam int N_DEF       = 27;
    localparam int TIMEOUT_DEF = 100000000;
    localparam int CLK_HZ      = 50000000;
endpackage

// File: rtl/sync_rise.sv
// sync_rise: 2-flop synchronizer plus history flop with rising-edge detect.
// Ports:
//   clk     in   system clock, rising edge
//   reset_n in   asynchronous active-low reset
//   sig_in  in   asynchronous input
//   level   out  synchronized level (second synchronizer flop)
//   rise    out  one-cycle pulse on a synchronized rising edge
module sync_rise (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic level,
    output logic rise
);
    logic s1, s2, s3;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {s3, s2, s1} <= 3'b000;
        end else begin
            {s3, s2, s1} <= {s2, s1, sig_in};
        end
    end
    assign level = s2;
    assign rise  = s2 & ~s3;
endmodule

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow square wave in clk cycles.
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   sig_in    in   measured signal, asynchronous to clk
//   period    out  cycles between the last two rising edges
//   high_time out  cycles high within that period (0 unless duty measurement built)
//   valid     out  one-cycle strobe when period/high_time update
//   timeout   out  no rising edge seen for TIMEOUT cycles
// Build option: define PERIOD_METER_DUTY_EN to build the high-time counter.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sig_in,
    output logic [N-1:0] period,
    output logic [N-1:0] high_time,
    output logic         valid,
    output logic         timeout
);
    localparam logic [N-1:0] TMO = N'(TIMEOUT);
    logic         level, rise;
    logic [0:0]   state;
    logic [N-1:0] cnt;
    sync_rise u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .sig_in (sig_in),
        .level  (level),
        .rise   (rise)
    );
    // cnt holds at TIMEOUT on expiry, so it never wraps; an edge on the
    // expiry cycle takes priority and reports the period instead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (rise) begin
                if (state == ST_MEASURE) begin
                    period  <= cnt;
                    valid   <= 1'b1;
                    timeout <= 1'b0;
                end
                state <= ST_MEASURE;
                cnt   <= N'(1);
            end else if (state == ST_MEASURE) begin
                if (cnt == TMO) begin
                    timeout <= 1'b1;
                    state   <= ST_IDLE;
                end else begin
                    cnt <= cnt + N'(1);
                end
            end
        end
    end
`ifdef PERIOD_METER_DUTY_EN
    logic [N-1:0] hi_cnt;
    // The edge cycle itself is high, hence the restart value of 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_cnt    <= '0;
            high_time <= '0;
        end else if (rise) begin
            if (state == ST_MEASURE) high_time <= hi_cnt;
            hi_cnt <= N'(1);
        end else if (state == ST_MEASURE && cnt != TMO) begin
            hi_cnt <= hi_cnt + N'(level);
        end
    end
`else
    logic unused_level;
    assign unused_level = level;
    assign high_time    = '0;
`endif
endmodule
